// File: rtl/alu_issue_stage_if.sv
// Bundle of the command, ALU-pin and result handshake signals of alu_issue_stage.
// The stage itself connects through `slave`; the surrounding logic uses `master`.
interface alu_issue_stage_if #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [3:0]    in_a;
    logic [3:0]    in_b;

    logic [1:0]    alu_sel;
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [3:0]    alu_sum;
    logic          alu_carry;
    logic [2:0]    alu_cmp;
    logic [3:0]    alu_and;

    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_op;
    logic [4:0]    out_res;
    logic [2:0]    out_flags;
    logic [LW-1:0] level;

    modport slave (
        input  in_valid, in_op, in_a, in_b,
        input  alu_sum, alu_carry, alu_cmp, alu_and,
        input  out_ready,
        output in_ready,
        output alu_sel, alu_a, alu_b,
        output out_valid, out_op, out_res, out_flags, level
    );

    modport master (
        output in_valid, in_op, in_a, in_b,
        output alu_sum, alu_carry, alu_cmp, alu_and,
        output out_ready,
        input  in_ready,
        input  alu_sel, alu_a, alu_b,
        input  out_valid, out_op, out_res, out_flags, level
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Command FIFO, issue register and result register wrapped around an external
// combinational 4-bit ALU; results leave in command order over valid/ready.
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              rst,
    alu_issue_stage_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic          iv_q, iv_d;
    cmd_t          issue_q, issue_d;

    logic          rv_q, rv_d;
    logic [1:0]    res_op_q, res_op_d;
    logic [4:0]    res_q, res_d;
    logic [2:0]    flags_q, flags_d;

    logic          full;
    logic          push;
    logic          pop;
    logic          adv;
    cmd_t          in_cmd;
    logic [4:0]    alu_res;
    logic [2:0]    alu_flags;

    assign full   = (level_q == LW'(DEPTH));
    assign in_cmd = '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
    assign push   = bus.in_valid && bus.in_ready;
    assign adv    = iv_q && (!rv_q || bus.out_ready);
    // Head is taken only when the issue slot is free or emptying this cycle.
    assign pop    = (level_q != '0) && (!iv_q || adv);

    assign bus.in_ready  = !full && !rst;
    assign bus.level     = level_q;
    assign bus.alu_sel   = iv_q ? issue_q.op : 2'b00;
    assign bus.alu_a     = iv_q ? issue_q.a  : 4'h0;
    assign bus.alu_b     = iv_q ? issue_q.b  : 4'h0;
    assign bus.out_valid = rv_q && !rst;
    assign bus.out_op    = res_op_q;
    assign bus.out_res   = res_q;
    assign bus.out_flags = flags_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_cmd;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        iv_d    = iv_q;
        issue_d = issue_q;
        if (pop) begin
            iv_d    = 1'b1;
            issue_d = mem_q[rd_ptr_q];
        end else if (adv) begin
            iv_d = 1'b0;
        end
    end

    // Only the compare op carries flags; the other ops report zero flags.
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        case (issue_q.op)
            2'b00, 2'b01: alu_res = {bus.alu_carry, bus.alu_sum};
            2'b10: begin
                alu_res   = {2'b00, bus.alu_cmp};
                alu_flags = bus.alu_cmp;
            end
            default:      alu_res = {1'b0, bus.alu_and};
        endcase
    end

    always_comb begin
        rv_d     = rv_q;
        res_op_d = res_op_q;
        res_d    = res_q;
        flags_d  = flags_q;
        if (adv) begin
            rv_d     = 1'b1;
            res_op_d = issue_q.op;
            res_d    = alu_res;
            flags_d  = alu_flags;
        end else if (rv_q && bus.out_ready) begin
            rv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            iv_q     <= 1'b0;
            issue_q  <= '0;
            rv_q     <= 1'b0;
            res_op_q <= '0;
            res_q    <= '0;
            flags_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            iv_q     <= iv_d;
            issue_q  <= issue_d;
            rv_q     <= rv_d;
            res_op_q <= res_op_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU on the pins and a
// scoreboard of expected results filled on each accepted command.
module tb_alu_issue_stage;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] res;
        logic [2:0] flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] alu_t;
    exp_t sb[$];
    exp_t head;
    int total = 0;
    int bad = 0;
    int accepted = 0;

    alu_issue_stage_if #(.DEPTH(DEPTH), .LW(LW)) bus ();

    alu_issue_stage #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: subtract is a + ~b + 1, so carry means "no borrow".
    always_comb begin
        alu_t = '0;
        if (bus.alu_sel == 2'b01) alu_t = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
        else                      alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_sum   = alu_t[3:0];
        bus.alu_carry = alu_t[4];
        bus.alu_cmp   = {bus.alu_a > bus.alu_b, bus.alu_a == bus.alu_b, bus.alu_a < bus.alu_b};
        bus.alu_and   = bus.alu_a & bus.alu_b;
    end

    function automatic exp_t expect_of(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.op    = op;
        e.flags = '0;
        case (op)
            2'b00: e.res = {1'b0, a} + {1'b0, b};
            2'b01: e.res = {a >= b, 4'(a - b)};
            2'b10: begin
                e.flags = {a > b, a == b, a < b};
                e.res   = {2'b00, e.flags};
            end
            default: e.res = {1'b0, a & b};
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    // Sample the handshakes at the falling edge, then step past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_expected_pending", 32'(sb.size() != 0), 1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_out_op", 32'(bus.out_op), 32'(e.op));
                    checkOutput("sb_out_res", 32'(bus.out_res), 32'(e.res));
                    checkOutput("sb_out_flags", 32'(bus.out_flags), 32'(e.flags));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(expect_of(bus.in_op, bus.in_a, bus.in_b));
                accepted++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
        bus.out_ready = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(bus.in_ready), 1);
        checkOutput("post_rst_level", 32'(bus.level), 0);
        checkOutput("post_rst_out_valid", 32'(bus.out_valid), 0);
        checkOutput("post_rst_out_op", 32'(bus.out_op), 0);
        checkOutput("post_rst_out_res", 32'(bus.out_res), 0);
        checkOutput("post_rst_out_flags", 32'(bus.out_flags), 0);
        checkOutput("post_rst_alu_sel", 32'(bus.alu_sel), 0);
        checkOutput("post_rst_alu_a", 32'(bus.alu_a), 0);
        checkOutput("post_rst_alu_b", 32'(bus.alu_b), 0);

        // Single add: 9 + 8 = 17 -> carry 1, sum 1, result at n+3.
        applyStimulus(1'b1, 2'b00, 4'd9, 4'd8);
        tick();
        applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
        checkOutput("add_n1_out_valid", 32'(bus.out_valid), 0);
        tick();
        checkOutput("add_n2_alu_sel", 32'(bus.alu_sel), 0);
        checkOutput("add_n2_alu_a", 32'(bus.alu_a), 9);
        checkOutput("add_n2_alu_b", 32'(bus.alu_b), 8);
        checkOutput("add_n2_out_valid", 32'(bus.out_valid), 0);
        tick();
        checkOutput("add_n3_out_valid", 32'(bus.out_valid), 1);
        checkOutput("add_n3_out_res", 32'(bus.out_res), 32'h11);
        checkOutput("add_n3_out_op", 32'(bus.out_op), 0);
        checkOutput("add_n3_out_flags", 32'(bus.out_flags), 0);
        checkOutput("add_n3_alu_a_drained", 32'(bus.alu_a), 0);
        tick();
        checkOutput("add_n4_out_valid", 32'(bus.out_valid), 0);

        // Mixed ops back-to-back: compare, AND, subtract.
        applyStimulus(1'b1, 2'b10, 4'd5, 4'd5);
        tick();
        applyStimulus(1'b1, 2'b11, 4'hC, 4'hA);
        tick();
        applyStimulus(1'b1, 2'b01, 4'd3, 4'd1);
        tick();
        applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
        checkOutput("mix_cmp_valid", 32'(bus.out_valid), 1);
        checkOutput("mix_cmp_op", 32'(bus.out_op), 2);
        checkOutput("mix_cmp_flags", 32'(bus.out_flags), 32'b010);
        checkOutput("mix_cmp_res", 32'(bus.out_res), 32'b00010);
        tick();
        checkOutput("mix_and_valid", 32'(bus.out_valid), 1);
        checkOutput("mix_and_res", 32'(bus.out_res), 32'b01000);
        tick();
        checkOutput("mix_sub_valid", 32'(bus.out_valid), 1);
        checkOutput("mix_sub_op", 32'(bus.out_op), 1);
        checkOutput("mix_sub_res", 32'(bus.out_res), 32'b10010);
        tick();
        checkOutput("mix_idle_valid", 32'(bus.out_valid), 0);

        // Backpressure: only DEPTH+2 commands fit while the output stalls.
        bus.out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'(i), 4'(i + 1), 4'(i));
            tick();
        end
        applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
        checkOutput("bp_accepted", 32'(accepted), DEPTH + 2);
        checkOutput("bp_in_ready", 32'(bus.in_ready), 0);
        checkOutput("bp_level", 32'(bus.level), DEPTH);
        checkOutput("bp_out_valid", 32'(bus.out_valid), 1);
        if (sb.size() > 0) begin
            head = sb[0];
            checkOutput("bp_hold_res", 32'(bus.out_res), 32'(head.res));
            tick();
            tick();
            checkOutput("bp_hold_res_later", 32'(bus.out_res), 32'(head.res));
            checkOutput("bp_hold_op_later", 32'(bus.out_op), 32'(head.op));
            checkOutput("bp_hold_level", 32'(bus.level), DEPTH);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            checkOutput("bp_drain_valid", 32'(bus.out_valid), 1);
            tick();
        end
        checkOutput("bp_drained_valid", 32'(bus.out_valid), 0);
        checkOutput("bp_sb_empty", 32'(sb.size()), 0);

        // Streaming with toggling out_ready across pointer wrap.
        accepted = 0;
        for (int cyc = 0; cyc < 200 && accepted < 20; cyc++) begin
            applyStimulus(1'b1, 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
            bus.out_ready = cyc[0];
            tick();
            checkOutput("wrap_level_max", 32'(bus.level <= LW'(DEPTH)), 1);
        end
        checkOutput("wrap_accepted", 32'(accepted), 20);
        applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        checkOutput("wrap_sb_empty", 32'(sb.size()), 0);
        tick();
        checkOutput("wrap_idle_valid", 32'(bus.out_valid), 0);

        // Reset mid-operation with a held result and three queued commands.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'b00, 4'(i), 4'd1);
            tick();
        end
        applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
        checkOutput("mid_pre_valid", 32'(bus.out_valid), 1);
        checkOutput("mid_pre_level", 32'(bus.level), 3);
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mid_out_valid", 32'(bus.out_valid), 0);
        checkOutput("mid_level", 32'(bus.level), 0);
        checkOutput("mid_alu_sel", 32'(bus.alu_sel), 0);
        checkOutput("mid_alu_a", 32'(bus.alu_a), 0);
        checkOutput("mid_alu_b", 32'(bus.alu_b), 0);
        checkOutput("mid_in_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("mid_no_stale", 32'(bus.out_valid), 0);
        end
        applyStimulus(1'b1, 2'b11, 4'hF, 4'h6);
        tick();
        applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
        tick();
        checkOutput("mid_fresh_n2_valid", 32'(bus.out_valid), 0);
        tick();
        checkOutput("mid_fresh_n3_valid", 32'(bus.out_valid), 1);
        checkOutput("mid_fresh_res", 32'(bus.out_res), 32'b00110);
        checkOutput("mid_fresh_op", 32'(bus.out_op), 3);
        tick();
        checkOutput("mid_fresh_sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Sequential front/back stage wrapped around the combinational 4-bit ALU (2-bit opcode: 00 add, 01 sub, 10 compare, 11 AND). Accepts commands `{op, a, b}` over a valid/ready handshake and buffers them in a small FIFO. Issues one command at a time to the ALU on stable registered pins, then captures the selected ALU outputs into a result register. That result register has its own valid/ready handshake toward downstream logic.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries; power of two, ≥ 2
- LW, $clog2(DEPTH+1), width of `level`

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command offered
- in_ready  out  1  FIFO can accept (= !full && !rst)
- in_op  in  2  opcode
- in_a  in  4  operand A
- in_b  in  4  operand B
- alu_sel  out  2  to ALU {s1,s0}
- alu_a  out  4  to ALU a3..a0; bit i drives ai
- alu_b  out  4  to ALU b3..b0; bit i drives bi
- alu_sum  in  4  from ALU s3_as..s0_as
- alu_carry  in  1  from ALU carry_as
- alu_cmp  in  3  from ALU {a_gt_b, a_eq_b, a_st_b}
- alu_and  in  4  from ALU ab_3..ab_0
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts
- out_op  out  2  opcode of held result
- out_res  out  5  packed result
- out_flags  out  3  {gt, eq, lt}; zero unless out_op = 10
- level  out  LW  FIFO occupancy, 0..DEPTH

## Operation
Three storage elements: FIFO, issue register (`iv`, op, a, b), and result register (`rv`, op, res, flags).
- **FIFO push:** `in_valid && in_ready`. There is no bypass: a pushed entry is poppable on the next cycle at the earliest. Push and pop may occur in the same cycle; `level` stays unchanged in that case.
- **Issue advance:** `adv = iv && (!rv || out_ready)`.
- **FIFO pop / issue load:** `level != 0 && (!iv || adv)`. The head entry is loaded into the issue register. `iv` clears on `adv` if no load occurs in the same cycle.
- **ALU pins:**
  - While `iv = 1`, `alu_sel`, `alu_a` and `alu_b` come straight from the issue register and are stable for the whole cycle.
  - While `iv = 0`, all three are 0.
- **Result load on `adv`:**
  - op 00 or 01: `out_res = {alu_carry, alu_sum}`, `out_flags = 0`.
  - op 10: `out_res = {2'b0, alu_cmp}`, `out_flags = alu_cmp`.
  - op 11: `out_res = {1'b0, alu_and}`, `out_flags = 0`.
  - `out_op` = issued op.
- **Result valid:** `rv` clears on `out_valid && out_ready` if no load occurs in the same cycle. `out_*` fields hold their values while `out_valid && !out_ready`.
- **Ordering:** results leave in command order; none are dropped or duplicated.

## Timing
- **Reset values** (while `rst` is high and after it): FIFO empty, `level = 0`, `iv = 0`, `rv = 0`, `out_valid = 0`, `out_op = 0`, `out_res = 0`, `out_flags = 0`, `alu_*` outputs = 0. `in_ready` is 0 during `rst` and 1 on the first cycle after.
- **Reset mid-operation:** discards all FIFO, issue and result contents. No partial result is emitted.
- **Latency:** a command handshaken in cycle n gives `out_valid` in cycle n+3, provided the pipe is empty and `out_ready = 1`.
- **Throughput:** one result per cycle while `out_ready = 1`.
- **Backpressure:** with `out_ready = 0`, the result register and issue register both hold. The FIFO then fills: after DEPTH further pushes, `in_ready` drops. At most DEPTH+2 commands are in flight.
- **Full:** `in_ready = 0`, and a push attempt is ignored even when a pop occurs in the same cycle.
- **Empty:** `iv` drains and the ALU pins go to 0 on the cycle after the last issue advances.
- **Pointer wrap:** read and write pointers wrap modulo DEPTH, with no gap and no reorder across the wrap.

## Test plan
The bench uses a behavioural ALU model on the `alu_*` pins.
- **Single add:** `rst` pulse, then push op=00, a=9, b=8 in cycle n, with `out_ready = 1`. Expect `out_valid` in cycle n+3 with `out_res = 5'b1_0001`, `out_op = 00`, `out_flags = 0`, and `alu_sel = 00`, `alu_a = 9`, `alu_b = 8` in cycle n+2.
- **Mixed ops back-to-back:** push (10, 5, 5), (11, 0xC, 0xA), (01, 3, 1) on consecutive cycles. Expect results in order on consecutive cycles:
  - compare: `out_flags = 010`, `out_res = 00010`
  - AND: `out_res = 01000`
  - sub: `out_res` equals the model's `{carry, diff}` for 3−1
- **Backpressure/full:** hold `out_ready = 0` and push 8 commands. Expect exactly DEPTH+2 = 6 accepted, `in_ready = 0` with `level = 4`, and outputs stable. Then release `out_ready`: all 6 results emerge in order, one per cycle.
- **Simultaneous push/pop at wrap:** stream 20 commands with `in_valid = 1` and `out_ready` toggling every cycle. Expect `level` never above DEPTH, no loss or duplication, and results in order across pointer wrap.
- **Reset mid-operation:** with 3 commands queued and `out_valid = 1`, assert `rst` for 1 cycle. Expect next cycle `out_valid = 0`, `level = 0`, `alu_* = 0`, and no stale results afterward; a fresh push completes with normal n+3 latency.
